instr_fetch_queue: RTL

Instruction fetch front end that produces the instruction stream consumed by the decode-stage control unit. Issues in-order word requests to instruction memory, buffers returned words with their PCs in a small queue, and presents one instruction per cycle to decode with a valid/ready handshake. A redirect from execute (taken branch, JAL, JALR) flushes the queue and silently drops responses still in flight.

---
 rtl/instr_fetch_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order instruction fetch front end with a small (instr, pc) queue
// Optional FETCH_BYPASS_EN: a response arriving at an empty queue goes straight to decode.
module instr_fetch_queue #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_resp_valid,
   input  logic [DATA_WIDTH-1:0] imem_resp_data,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] InstrD,
   output logic [DATA_WIDTH-1:0] PCD,
   output logic [DATA_WIDTH-1:0] PCPlus4D
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d, outst_q, outst_d, drop_q, drop_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d, last_pc_q, last_pc_d;

   logic                  req_fire, resp_keep, bypass, push, pop, q_valid;
   logic [CW:0]           credits_used;
   logic [DATA_WIDTH-1:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & ~DATA_WIDTH'(3);
   // Queued entries plus in-flight requests never exceed DEPTH, so a push always finds room.
   assign credits_used   = {1'b0, count_q} + {1'b0, outst_q};
   assign imem_req_valid = !rst && !redirect && (credits_used < (CW+1)'(DEPTH));
   assign imem_addr      = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign q_valid   = (count_q != '0);
   assign resp_keep = imem_resp_valid && (drop_q == '0) && !redirect && !rst;
`ifdef FETCH_BYPASS_EN
   assign bypass = resp_keep && !q_valid && instr_ready;
`else
   assign bypass = 1'b0;
`endif
   assign push = resp_keep && !bypass;
   assign pop  = q_valid && instr_ready && !redirect;

   assign instr_valid = q_valid || bypass;

   always_comb begin
      if (q_valid) begin
         InstrD = instr_mem_q[head_q];
         PCD    = pc_mem_q[head_q];
      end else if (bypass) begin
         InstrD = imem_resp_data;
         PCD    = resp_pc_q;
      end else begin
         InstrD = NOP_INSTR;
         PCD    = last_pc_q;
      end
   end
   assign PCPlus4D = PCD + DATA_WIDTH'(4);

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      drop_d    = drop_q;
      outst_d   = outst_q + CW'(req_fire) - CW'(imem_resp_valid);
      last_pc_d = instr_valid ? PCD : last_pc_q;
      if (redirect) begin
         // Everything still in flight after this cycle belongs to the old stream.
         pc_d      = redirect_aligned;
         resp_pc_d = redirect_aligned;
         head_d    = '0;
         tail_d    = '0;
         count_d   = '0;
         drop_d    = outst_q - CW'(imem_resp_valid);
      end else begin
         if (req_fire) pc_d = pc_q + DATA_WIDTH'(4);
         if (imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
         if (resp_keep) resp_pc_d = resp_pc_q + DATA_WIDTH'(4);
         if (push) tail_d = tail_q + PW'(1);
         if (pop) head_d = head_q + PW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         last_pc_q <= RESET_PC;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         outst_q   <= '0;
         drop_q    <= '0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         last_pc_q <= last_pc_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         outst_q   <= outst_d;
         drop_q    <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem_q[tail_q] <= imem_resp_data;
         pc_mem_q[tail_q]    <= resp_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && (count_q == CW'(DEPTH))));
   end
endmodule
